// File: rtl/dmem_responder_if.sv
// Request/response bus between the CPU load/store port and the data-memory
// responder. The CPU side is the master, the memory responder is the slave.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers one load/store at a time over a
// valid/ready handshake, after a fixed number of wait states. Misaligned or
// out-of-range accesses produce an error response and never touch memory.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input logic              clk,
  input logic              rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN_BYTES = 32'd4 << DEPTH_LOG2;
  // Counter reload value; the access happens on the edge where it reads 0,
  // so LATENCY wait edges need a start value of LATENCY-1.
  localparam logic [3:0]  LAT_RELOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    RST,
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  waitCnt_q, waitCnt_d;
  logic        reqWrite_q, reqWrite_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic [31:0] reqWdata_q, reqWdata_d;
  logic [3:0]  reqBe_q, reqBe_d;
  logic        reqReady_q, reqReady_d;
  logic        rspValid_q, rspValid_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspErr_q, rspErr_d;

  logic [31:0] mem [0:DEPTH-1];

  logic                  accWrite;
  logic [31:0]           accAddr;
  logic [31:0]           accWdata;
  logic [3:0]            accBe;
  logic [31:0]           accOffset;
  logic [DEPTH_LOG2-1:0] accIdx;
  logic                  accErr;
  logic                  doAccess;
  logic                  memWe;

  // Pick the request fields used for the memory access: with zero wait
  // states the access happens on the accept edge, before capture registers
  // have loaded, so the live bus fields are used in IDLE.
  always_comb begin
    accWrite = reqWrite_q;
    accAddr  = reqAddr_q;
    accWdata = reqWdata_q;
    accBe    = reqBe_q;
    if (state_q == IDLE) begin
      accWrite = bus.req_write;
      accAddr  = bus.req_addr;
      accWdata = bus.req_wdata;
      accBe    = bus.req_be;
    end
  end

  // Address decode: offset wraps in 32 bits, so addresses below the base
  // turn into huge offsets and fall out of range naturally.
  always_comb begin
    accOffset = accAddr - BASE_ADDR;
    accIdx    = accOffset[DEPTH_LOG2+1:2];
    accErr    = (accAddr[1:0] != 2'b00) || (accOffset >= SPAN_BYTES);
  end

  // Next-state and registered-output logic of the request/response FSM.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    reqWrite_d = reqWrite_q;
    reqAddr_d  = reqAddr_q;
    reqWdata_d = reqWdata_q;
    reqBe_d    = reqBe_q;
    reqReady_d = reqReady_q;
    rspValid_d = rspValid_q;
    rspRdata_d = rspRdata_q;
    rspErr_d   = rspErr_q;
    doAccess   = 1'b0;

    case (state_q)
      RST: begin
        state_d    = IDLE;
        reqReady_d = 1'b1;
      end
      IDLE: begin
        if (bus.req_valid && reqReady_q) begin
          reqWrite_d = bus.req_write;
          reqAddr_d  = bus.req_addr;
          reqWdata_d = bus.req_wdata;
          reqBe_d    = bus.req_be;
          reqReady_d = 1'b0;
          if (LATENCY == 0) begin
            doAccess = 1'b1;
            state_d  = RESP;
          end else begin
            waitCnt_d = LAT_RELOAD;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == 4'd0) begin
          doAccess = 1'b1;
          state_d  = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rspValid_d = 1'b0;
          rspRdata_d = 32'd0;
          rspErr_d   = 1'b0;
          reqReady_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = RST;
      end
    endcase

    // The access edge loads the response; stores and errors return zero data.
    if (doAccess) begin
      rspValid_d = 1'b1;
      rspErr_d   = accErr;
      if (accErr || accWrite) begin
        rspRdata_d = 32'd0;
      end else begin
        rspRdata_d = mem[accIdx];
      end
    end
  end

  // Only a valid store commits to memory, and only on its access edge.
  always_comb begin
    memWe = doAccess && accWrite && !accErr;
  end

  // Control and response registers; reset abandons any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST;
      waitCnt_q  <= 4'd0;
      reqWrite_q <= 1'b0;
      reqAddr_q  <= 32'd0;
      reqWdata_q <= 32'd0;
      reqBe_q    <= 4'd0;
      reqReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'd0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      reqWrite_q <= reqWrite_d;
      reqAddr_q  <= reqAddr_d;
      reqWdata_q <= reqWdata_d;
      reqBe_q    <= reqBe_d;
      reqReady_q <= reqReady_d;
      rspValid_q <= rspValid_d;
      rspRdata_q <= rspRdata_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Byte-masked memory write; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (accBe[b]) begin
          mem[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = reqReady_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder. Three instances with 0, 2 and 4 wait
// states share the request drivers; dutSel steers req_valid and the monitor
// view to one of them. Expected responses are queued at issue time and a
// monitor pops them whenever a response handshake is observed.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr = 32'd0;
  logic [31:0] reqWdata = 32'd0;
  logic [3:0]  reqBe = 4'd0;
  logic        rspReady = 1'b1;
  int          dutSel = 2;

  logic        monReqReady;
  logic        monRspValid;
  logic [31:0] monRspRdata;
  logic        monRspErr;

  int errors = 0;
  int checks = 0;

  logic [31:0] expDataQ[$];
  logic        expErrQ[$];
  string       expNameQ[$];

  dmem_responder_if if0 ();
  dmem_responder_if if2 ();
  dmem_responder_if if4 ();

  // Shared request fields; only the selected instance sees req_valid.
  assign if0.req_valid = reqValid && (dutSel == 0);
  assign if2.req_valid = reqValid && (dutSel == 2);
  assign if4.req_valid = reqValid && (dutSel == 4);
  assign if0.req_write = reqWrite;
  assign if2.req_write = reqWrite;
  assign if4.req_write = reqWrite;
  assign if0.req_addr  = reqAddr;
  assign if2.req_addr  = reqAddr;
  assign if4.req_addr  = reqAddr;
  assign if0.req_wdata = reqWdata;
  assign if2.req_wdata = reqWdata;
  assign if4.req_wdata = reqWdata;
  assign if0.req_be    = reqBe;
  assign if2.req_be    = reqBe;
  assign if4.req_be    = reqBe;
  assign if0.rsp_ready = rspReady;
  assign if2.rsp_ready = rspReady;
  assign if4.rsp_ready = rspReady;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BASE_ADDR(32'h1000_0000))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(32'h1000_0000))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(4), .BASE_ADDR(32'h1000_0000))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  always #5 clk = ~clk;

  // Monitor view of the selected instance.
  always_comb begin
    case (dutSel)
      0: begin
        monReqReady = if0.req_ready;
        monRspValid = if0.rsp_valid;
        monRspRdata = if0.rsp_rdata;
        monRspErr   = if0.rsp_err;
      end
      4: begin
        monReqReady = if4.req_ready;
        monRspValid = if4.rsp_valid;
        monRspRdata = if4.rsp_rdata;
        monRspErr   = if4.rsp_err;
      end
      default: begin
        monReqReady = if2.req_ready;
        monRspValid = if2.rsp_valid;
        monRspRdata = if2.rsp_rdata;
        monRspErr   = if2.rsp_err;
      end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: actual=timeout required=handshake", name);
  endtask

  // Response monitor: a handshake is seen at the negedge before the edge
  // that completes it, while valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && monRspValid && rspReady) begin
      if (expDataQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedRsp: actual=rdata %h err %0b required=no response",
                 monRspRdata, monRspErr);
      end else begin
        automatic string nm = expNameQ.pop_front();
        automatic logic [31:0] ed = expDataQ.pop_front();
        automatic logic ee = expErrQ.pop_front();
        checkOutput({nm, ".rdata"}, monRspRdata, ed);
        checkOutput({nm, ".err"}, {31'd0, monRspErr}, {31'd0, ee});
      end
    end
  end

  // Drive a request and hold it until the selected instance accepts it.
  task automatic issueRequest(input string name, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output bit accepted);
    @(posedge clk);
    #1;
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqWdata = wdata;
    reqBe    = be;
    accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (monReqReady) begin
        accepted = 1'b1;
        break;
      end
    end
    if (accepted) begin
      @(posedge clk);
      #1;
    end else begin
      reportTimeout({name, ".accept"});
    end
    reqValid = 1'b0;
  endtask

  // Issue one transaction, queue its expected response and check the number
  // of cycles from acceptance to rsp_valid.
  task automatic applyStimulus(input string name, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic [31:0] expData,
                               input logic expErr, input int expLat,
                               input bit expectRsp, input bit holdRsp);
    bit acc;
    bit seen;
    int lat;
    if (expectRsp) begin
      expNameQ.push_back(name);
      expDataQ.push_back(expData);
      expErrQ.push_back(expErr);
    end
    issueRequest(name, wr, addr, wdata, be, acc);
    if (!acc) return;
    seen = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (monRspValid) begin
        seen = 1'b1;
        lat = n;
        break;
      end
    end
    if (!seen) begin
      reportTimeout({name, ".rspValid"});
      return;
    end
    checkOutput({name, ".latency"}, lat, expLat);
    if (!holdRsp) begin
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (monReqReady) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) reportTimeout({name, ".reqReadyAgain"});
    end
  endtask

  initial begin
    bit acc;
    bit sawValid;

    // Reset held for three cycles, then released.
    dutSel = 2;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("resetReqReady", {31'd0, monReqReady}, 32'd0);
      checkOutput("resetRspValid", {31'd0, monRspValid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idleReqReady", {31'd0, monReqReady}, 32'd1);
    checkOutput("idleRspValid", {31'd0, monRspValid}, 32'd0);
    @(negedge clk);
    checkOutput("idleRspValid2", {31'd0, monRspValid}, 32'd0);

    // Round trip and byte enables on the two-wait-state instance.
    rspReady = 1'b1;
    applyStimulus("storeBeef", 1'b1, 32'h1000_0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("loadBeef", 1'b0, 32'h1000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("storeFull", 1'b1, 32'h1000_0000, 32'h11223344, 4'hF, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("storeMask", 1'b1, 32'h1000_0000, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("loadMask", 1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("storeNoBe", 1'b1, 32'h1000_0010, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("loadNoBe", 1'b0, 32'h1000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0);

    // Error cases and the last valid word.
    applyStimulus("loadMisalign", 1'b0, 32'h1000_0002, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus("storeOob", 1'b1, 32'h1000_1000, 32'h0, 4'hF, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus("storeMisalign", 1'b1, 32'h1000_0001, 32'h0, 4'hF, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus("loadAfterErr", 1'b0, 32'h1000_0000, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("loadBelowBase", 1'b0, 32'h0FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b1, 1'b0);
    applyStimulus("storeLast", 1'b1, 32'h1000_0FFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 3, 1'b1, 1'b0);
    applyStimulus("loadLast", 1'b0, 32'h1000_0FFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1, 1'b0);

    // Response backpressure: stalled response holds, stray request ignored.
    rspReady = 1'b0;
    applyStimulus("loadStall", 1'b0, 32'h1000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallRspValid", {31'd0, monRspValid}, 32'd1);
      checkOutput("stallRdata", monRspRdata, 32'hDEADBEEF);
      checkOutput("stallReqReady", {31'd0, monReqReady}, 32'd0);
      if (i == 1) begin
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 32'h1000_0010;
        reqWdata = 32'h12345678;
        reqBe    = 4'hF;
      end
      if (i == 3) reqValid = 1'b0;
    end
    @(posedge clk);
    #1;
    rspReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("afterStallReqReady", {31'd0, monReqReady}, 32'd1);
    checkOutput("afterStallRspValid", {31'd0, monRspValid}, 32'd0);
    applyStimulus("loadNotClobbered", 1'b0, 32'h1000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1, 1'b0);

    // A store already in RESP is committed even if reset discards its response.
    rspReady = 1'b0;
    applyStimulus("storeCommit", 1'b1, 32'h1000_0004, 32'h600DF00D, 4'hF, 32'h0, 1'b0, 3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midRstReqReady", {31'd0, monReqReady}, 32'd0);
    checkOutput("midRstRspValid", {31'd0, monRspValid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rspReady = 1'b1;
    applyStimulus("loadCommit", 1'b0, 32'h1000_0004, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 3, 1'b1, 1'b0);

    // Four wait states: reset one cycle after accepting a store drops it.
    dutSel = 4;
    applyStimulus("preStore4", 1'b1, 32'h1000_0020, 32'h00000077, 4'hF, 32'h0, 1'b0, 5, 1'b1, 1'b0);
    issueRequest("dropStore4", 1'b1, 32'h1000_0020, 32'h00000055, 4'hF, acc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (monRspValid) sawValid = 1'b1;
    end
    checkOutput("dropNoRsp", {31'd0, sawValid}, 32'd0);
    checkOutput("dropReqReady", {31'd0, monReqReady}, 32'd1);
    applyStimulus("loadPreStore4", 1'b0, 32'h1000_0020, 32'h0, 4'h0, 32'h00000077, 1'b0, 5, 1'b1, 1'b0);

    // Zero wait states: response in the cycle after acceptance.
    dutSel = 0;
    applyStimulus("store0", 1'b1, 32'h1000_0008, 32'h0BADCAFE, 4'hF, 32'h0, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus("load0", 1'b0, 32'h1000_0008, 32'h0, 4'h0, 32'h0BADCAFE, 1'b0, 1, 1'b1, 1'b0);
    applyStimulus("load0Err", 1'b0, 32'h1000_0003, 32'h0, 4'h0, 32'h0, 1'b1, 1, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", expDataQ.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls beyond its budget.
  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
